// File: rtl/rds_pkg.sv
// Shared constants and types for the RDS BPSK transmit path.
// Carrier: 57 kHz sampled at 456 kHz, so 8 samples per carrier cycle.
// Bit rate: 1187.5 bit/s, so 48 carrier cycles (384 samples) per data bit.
package rds_pkg;

  localparam int SAMPLES_PER_CYCLE = 8;
  localparam int CYCLES_PER_BIT    = 48;
  localparam int SAMPLES_PER_BIT   = SAMPLES_PER_CYCLE * CYCLES_PER_BIT;
  localparam int HALF_BIT          = SAMPLES_PER_BIT / 2;

  // One carrier cycle, peak amplitude 16384.
  localparam logic signed [15:0] SINE_LUT [SAMPLES_PER_CYCLE] = '{
    16'sd0, 16'sd11585, 16'sd16384, 16'sd11585,
    16'sd0, -16'sd11585, -16'sd16384, -16'sd11585
  };

  typedef enum logic {IDLE, RUN} state_t;

  // Sample index within one bit period, 0..383.
  typedef logic [8:0] sample_idx_t;

endpackage

// File: rtl/rds_diff_biphase_encoder.sv
// Differential encoder plus biphase polarity selection.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : a new data bit d enters the symbol this cycle
//   d         : data bit to encode
//   n         : sample index (0..383) of the sample being computed
//   e         : encoded bit in force for that sample
//   pol_neg   : 1 when the biphase waveform is -1 at sample n
module rds_diff_biphase_encoder
  import rds_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        d,
  input  sample_idx_t n,
  output logic        e,
  output logic        pol_neg
);

  // prev_e doubles as the encoded value of the symbol currently on air.
  logic prev_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_e <= 1'b0;
    end else if (load) begin
      prev_e <= d ^ prev_e;
    end
  end

  // On a load the sample being computed already belongs to the new symbol.
  assign e = load ? (d ^ prev_e) : prev_e;

  // e=1: +1 then -1; e=0: -1 then +1.
  assign pol_neg = ~(e ^ (n >= sample_idx_t'(HALF_BIT)));

endmodule

// File: rtl/rds_bpsk_modulator.sv
// RDS BPSK modulator: AXIS data bits in, 57 kHz BPSK subcarrier samples out.
// Ports:
//   s00_axis_aclk / s00_axis_areset : clock, synchronous active-high reset
//   s00_axis_*  : input bit stream, bit in tdata[0], one-entry holding register
//   m00_axis_*  : output samples, 16-bit signed sign-extended, tlast at n=383
//   shift       : arithmetic right shift applied to every sample
//   underrun    : sticky, set when a bit period ends with no next bit queued
module rds_bpsk_modulator
  import rds_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic [3:0]                          shift,
  output logic                                underrun
);

  state_t             state;
  logic               hold_valid;
  logic               hold_bit;
  sample_idx_t        n;
  sample_idx_t        n_next;
  logic               out_hs;
  logic               last_idx;
  logic               load;
  logic               enc_e;
  logic               pol_neg;
  logic signed [15:0] lut_val;
  logic signed [15:0] raw;
  logic signed [15:0] smp;
  logic               unused_tdata_hi;

  assign unused_tdata_hi = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1];

  assign s00_axis_tready = !hold_valid;
  assign m00_axis_tstrb  = '1;

  assign out_hs   = m00_axis_tvalid && m00_axis_tready;
  assign last_idx = (n == sample_idx_t'(SAMPLES_PER_BIT - 1));

  // A held bit is only consumed from IDLE or exactly at a bit boundary, so a
  // bit arriving on the boundary cycle itself is not seen until IDLE.
  assign load = hold_valid && ((state == IDLE) || (out_hs && last_idx));

  // Index of the sample that will be registered on this edge.
  assign n_next = load ? '0 : n + 9'd1;

  rds_diff_biphase_encoder u_enc (
    .clk     (s00_axis_aclk),
    .rst     (s00_axis_areset),
    .load    (load),
    .d       (hold_bit),
    .n       (n_next),
    .e       (enc_e),
    .pol_neg (pol_neg)
  );

  assign lut_val = SINE_LUT[n_next[2:0]];
  assign raw     = pol_neg ? -lut_val : lut_val;
  assign smp     = raw >>> shift;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state           <= IDLE;
      hold_valid      <= 1'b0;
      hold_bit        <= 1'b0;
      n               <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      if (load) begin
        hold_valid <= 1'b0;
      end else if (s00_axis_tvalid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_bit   <= s00_axis_tdata[0];
      end

      case (state)
        IDLE: begin
          if (load) begin
            state           <= RUN;
            n               <= n_next;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(smp);
            m00_axis_tlast  <= 1'b0;
          end
        end
        RUN: begin
          if (out_hs) begin
            if (!last_idx || load) begin
              n               <= n_next;
              m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(smp);
              m00_axis_tlast  <= (n_next == sample_idx_t'(SAMPLES_PER_BIT - 1));
            end else begin
              state           <= IDLE;
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              underrun        <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rds_bpsk_modulator.sv
module tb_rds_bpsk_modulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic        m_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic [3:0]  shift;
  logic        underrun;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] cap_data    [384];
  logic        cap_last    [384];
  logic [31:0] stall_data  [16];
  logic        stall_last  [16];
  logic        stall_valid [16];

  always #5 clk = ~clk;

  rds_bpsk_modulator #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tready (s_tready),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .shift           (shift),
    .underrun        (underrun)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns on the negedge after the transfer edge. Upper tdata bits are junk.
  task automatic send_bit(input logic b);
    int cnt = 0;
    s_tvalid = 1'b1;
    s_tdata  = {31'h52D2_D2D2, b};
    while (!s_tready && cnt < 1000) begin
      @(negedge clk); cnt++;
    end
    n_compared++;
    if (!s_tready) begin
      n_mismatched++;
      $display("FAIL send_bit_tready: got 0 required 1 after %0d cycles", cnt);
    end
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // Takes up to max_hs handshakes, observing on negedges. While hs==stall_at
  // the sink withholds tready for stall_len cycles and logs what it sees.
  task automatic capture(input int max_hs, input int stall_at, input int stall_len,
                         output int hs);
    int cyc = 0;
    int st  = 0;
    hs = 0;
    while (hs < max_hs && cyc < 3000) begin
      if (hs == stall_at && st < stall_len) begin
        m_tready = 1'b0;
        stall_data[st]  = m_tdata;
        stall_last[st]  = m_tlast;
        stall_valid[st] = m_tvalid;
        st++;
      end else begin
        m_tready = 1'b1;
        if (m_tvalid) begin
          cap_data[hs] = m_tdata;
          cap_last[hs] = m_tlast;
          hs++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h1; m_tready = 1'b1; shift = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || underrun !== 1'b0 || s_tready !== 1'b1) begin
        n_mismatched++;
        $display("FAIL reset_values[%0d]: got tvalid=%b tdata=%h underrun=%b tready=%b required 0 0 0 1",
                 i, m_tvalid, m_tdata, underrun, s_tready);
      end
    end
    n_compared++;
    if (m_tstrb !== 4'hF) begin
      n_mismatched++;
      $display("FAIL tstrb: got %h required f", m_tstrb);
    end
    s_tvalid = 1'b0; m_tready = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_bit();
    int hs;
    int tl_cnt = 0;
    apply_reset();
    send_bit(1'b1);
    n_compared++;
    if (m_tvalid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL single_tvalid_cycle1: got %b required 0", m_tvalid);
    end
    @(negedge clk);
    n_compared++;
    if (m_tvalid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL single_tvalid_cycle2: got %b required 1", m_tvalid);
    end
    capture(384, -1, 0, hs);
    n_compared++;
    if (hs !== 384) begin
      n_mismatched++;
      $display("FAIL single_handshakes: got %0d required 384", hs);
    end
    n_compared++;
    if (cap_data[0] !== 32'h0000_0000 || cap_data[2] !== 32'h0000_4000) begin
      n_mismatched++;
      $display("FAIL single_n0_n2: got %h %h required 00000000 00004000", cap_data[0], cap_data[2]);
    end
    n_compared++;
    if (cap_data[5] !== 32'hFFFF_D2BF) begin  // -11585
      n_mismatched++;
      $display("FAIL single_n5: got %h required ffffd2bf", cap_data[5]);
    end
    n_compared++;
    if (cap_data[194] !== 32'hFFFF_C000) begin  // -16384
      n_mismatched++;
      $display("FAIL single_n194: got %h required ffffc000", cap_data[194]);
    end
    for (int i = 0; i < 384; i++) if (cap_last[i] === 1'b1) tl_cnt++;
    n_compared++;
    if (tl_cnt !== 1 || cap_last[383] !== 1'b1) begin
      n_mismatched++;
      $display("FAIL single_tlast: got count=%0d last383=%b required 1 1", tl_cnt, cap_last[383]);
    end
    n_compared++;
    if (m_tvalid !== 1'b0 || underrun !== 1'b1) begin
      n_mismatched++;
      $display("FAIL single_end: got tvalid=%b underrun=%b required 0 1", m_tvalid, underrun);
    end
    @(negedge clk);
    n_compared++;
    if (m_tvalid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL single_idle: got tvalid=%b required 0", m_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    int hs;
    apply_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    capture(384, -1, 0, hs);
    n_compared++;
    if (hs !== 384 || cap_data[2] !== 32'h0000_4000 || cap_last[383] !== 1'b1) begin
      n_mismatched++;
      $display("FAIL b2b_first: got hs=%0d n2=%h last=%b required 384 00004000 1",
               hs, cap_data[2], cap_last[383]);
    end
    n_compared++;
    if (m_tvalid !== 1'b1 || underrun !== 1'b0 || m_tlast !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_no_gap: got tvalid=%b underrun=%b tlast=%b required 1 0 0",
               m_tvalid, underrun, m_tlast);
    end
    capture(384, -1, 0, hs);
    n_compared++;
    if (hs !== 384) begin
      n_mismatched++;
      $display("FAIL b2b_second_hs: got %0d required 384", hs);
    end
    n_compared++;
    if (cap_data[0] !== 32'h0 || cap_data[2] !== 32'hFFFF_C000) begin
      n_mismatched++;
      $display("FAIL b2b_second_n2: got %h %h required 00000000 ffffc000", cap_data[0], cap_data[2]);
    end
    n_compared++;
    if (cap_data[194] !== 32'h0000_4000) begin
      n_mismatched++;
      $display("FAIL b2b_second_n194: got %h required 00004000", cap_data[194]);
    end
    n_compared++;
    if (underrun !== 1'b1 || m_tvalid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_end: got underrun=%b tvalid=%b required 1 0", underrun, m_tvalid);
    end
  endtask

  task automatic test_backpressure();
    int hs;
    int tl_cnt = 0;
    apply_reset();
    send_bit(1'b1);
    @(negedge clk);
    capture(384, 100, 10, hs);
    n_compared++;
    if (hs !== 384) begin
      n_mismatched++;
      $display("FAIL bp_handshakes: got %0d required 384", hs);
    end
    for (int i = 0; i < 10; i++) begin
      n_compared++;
      if (stall_valid[i] !== 1'b1 || stall_data[i] !== 32'h0 || stall_last[i] !== 1'b0) begin
        n_mismatched++;
        $display("FAIL bp_frozen[%0d]: got tvalid=%b tdata=%h tlast=%b required 1 00000000 0",
                 i, stall_valid[i], stall_data[i], stall_last[i]);
      end
    end
    n_compared++;
    if (cap_data[100] !== 32'h0 || cap_data[101] !== 32'hFFFF_D2BF) begin
      n_mismatched++;
      $display("FAIL bp_resume: got n100=%h n101=%h required 00000000 ffffd2bf",
               cap_data[100], cap_data[101]);
    end
    for (int i = 0; i < 384; i++) if (cap_last[i] === 1'b1) tl_cnt++;
    n_compared++;
    if (tl_cnt !== 1 || cap_last[383] !== 1'b1) begin
      n_mismatched++;
      $display("FAIL bp_tlast: got count=%0d last383=%b required 1 1", tl_cnt, cap_last[383]);
    end
  endtask

  task automatic test_shift();
    int hs;
    apply_reset();
    shift = 4'd4;
    send_bit(1'b1);
    @(negedge clk);
    capture(384, -1, 0, hs);
    n_compared++;
    if (cap_data[2] !== 32'h0000_0400) begin  // 1024
      n_mismatched++;
      $display("FAIL shift_n2: got %h required 00000400", cap_data[2]);
    end
    n_compared++;
    if (cap_data[5] !== 32'hFFFF_FD2B) begin  // floor(-11585/16) = -725
      n_mismatched++;
      $display("FAIL shift_n5: got %h required fffffd2b", cap_data[5]);
    end
    n_compared++;
    if (cap_data[194] !== 32'hFFFF_FC00) begin  // -1024
      n_mismatched++;
      $display("FAIL shift_n194: got %h required fffffc00", cap_data[194]);
    end
    shift = 4'd0;
  endtask

  task automatic test_reset_mid();
    int hs;
    apply_reset();
    send_bit(1'b1);
    @(negedge clk);
    capture(150, -1, 0, hs);
    n_compared++;
    if (hs !== 150 || m_tvalid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL mid_reach150: got hs=%0d tvalid=%b required 150 1", hs, m_tvalid);
    end
    send_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_compared++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || m_tdata !== 32'h0 || underrun !== 1'b0) begin
      n_mismatched++;
      $display("FAIL mid_reset: got tvalid=%b tready=%b tdata=%h underrun=%b required 0 1 00000000 0",
               m_tvalid, s_tready, m_tdata, underrun);
    end
    rst = 1'b0;
    send_bit(1'b1);
    @(negedge clk);
    capture(384, -1, 0, hs);
    n_compared++;
    if (hs !== 384 || cap_data[2] !== 32'h0000_4000) begin
      n_mismatched++;
      $display("FAIL mid_new_bit: got hs=%0d n2=%h required 384 00004000", hs, cap_data[2]);
    end
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 32'h0; m_tready = 1'b0; shift = 4'd0;
    test_reset();
    test_single_bit();
    test_back_to_back();
    test_backpressure();
    test_shift();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
